if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage ARM-subset pipeline. Holds the PC and
//  reads the word-indexed instruction ROM combinationally (index = pc>>2).
//  Registers {pc+4, instruction, valid} into the IF/ID boundary for the ID stage.
//  Supports hazard freeze (stall) and branch redirect with flush.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  MEM_DEPTH  32             instruction ROM depth in words
//  NOP_INST   32'h0000_0000  word injected on flush/reset/out-of-range fetch
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   synchronous, active-high reset
//  freeze        in   1   hazard-unit stall: hold PC and IF/ID contents
//  branch_taken  in   1   EX-stage branch resolved taken this cycle
//  branch_addr   in   32  branch target (byte address, word-aligned)
//  if_pc         out  32  current PC (combinational from PC register)
//  id_pc         out  32  registered pc+4 of the instruction held in IF/ID
//  id_inst       out  32  registered instruction held in IF/ID
//  id_valid      out  1   IF/ID holds a real fetched instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc<=RESET_PC; id_pc<=0; id_inst<=NOP_INST;
//   id_valid<=0. rst overrides every other input.
//  Fetch: inst = (pc>>2) < MEM_DEPTH ? rom[pc>>2] : NOP_INST; pc_plus4 = pc+32'd4
//   (32-bit, wraps modulo 2^32, no carry out). Latency fetch->id_*: 1 cycle.
//  Per posedge, priority (highest first):
//   1 rst            : as above.
//   2 branch_taken=1 : pc<=branch_addr; id_inst<=NOP_INST; id_pc<=0;
//                      id_valid<=0 (flush wrong-path fetch). Wins over freeze.
//   3 freeze=1       : pc and all id_* hold their values.
//   4 otherwise      : pc<=pc_plus4; id_pc<=pc_plus4; id_inst<=inst; id_valid<=1
//                      (id_valid=1 even on out-of-range NOP fetch).
//  branch_addr[1:0] ignored (treated as 0); no misalignment fault.
//  Back-to-back branches: each flushes; second target wins next cycle.
//  Branch on first cycle after reset: legal, target loaded, no valid issued.
//  freeze held N cycles: outputs stable N cycles, no fetch lost or duplicated.
//  No combinational path from freeze/branch_taken to id_* outputs.
// STRUCTURE
//  Shared package (arm_pkg): WORD_W=32, NOP_INST, COND_AL=4'b1110, opcode
//   constants used by ROM contents and decoder.
//  Sub-module: if_id_reg (id_pc/id_inst/id_valid with rst, flush, freeze
//   enables). PC register, +4 adder, branch mux stay inline; ROM instantiated
//   as instruction_rom (pc in, inst out, combinational).
// TESTING
//  T1 rst 2 cycles, release -> cycle0 if_pc=0, id_valid=0; next edge id_pc=4,
//     id_inst=rom[0], id_valid=1.
//  T2 free-run 10 cycles -> id_pc steps 4,8,..,40; id_inst=rom[k] each cycle.
//  T3 freeze high 3 cycles at if_pc=0x10 -> if_pc stays 0x10, id_* unchanged;
//     drop freeze -> id_pc=0x14, id_inst=rom[4], no skipped word.
//  T4 branch_taken=1, branch_addr=0x3C with freeze=1 -> next edge if_pc=0x3C,
//     id_inst=NOP_INST, id_valid=0; following edge id_pc=0x40, id_inst=rom[15].
//  T5 branch_addr=0x80 (>= MEM_DEPTH*4) -> id_inst=NOP_INST, id_valid=1,
//     id_pc=0x84; branch_addr=0xFFFF_FFFC -> id_pc wraps to 0x0000_0000.
//  T6 rst asserted mid-run with freeze=1 and branch_taken=1 -> next edge
//     if_pc=RESET_PC, id_valid=0, id_inst=NOP_INST.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM-subset constants and instruction ROM image helper
package arm_pkg;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [3:0]  COND_AL  = 4'b1110;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_MOV = 4'b1101;

    // ROM word i: ADD r(i+1), r(i), #i  (data-processing, immediate form)
    function automatic logic [WORD_W-1:0] rom_word(input int unsigned i);
        return {COND_AL, 2'b00, 1'b1, OPC_ADD, 1'b0, 4'(i), 4'(i + 1), 12'(i)};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - control inputs and IF/ID outputs of the fetch stage
interface if_stage_if;
    import arm_pkg::*;

    logic              freeze;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_addr;
    logic [WORD_W-1:0] if_pc;
    logic [WORD_W-1:0] id_pc;
    logic [WORD_W-1:0] id_inst;
    logic              id_valid;

    modport master (
        output freeze, branch_taken, branch_addr,
        input  if_pc, id_pc, id_inst, id_valid
    );

    modport slave (
        input  freeze, branch_taken, branch_addr,
        output if_pc, id_pc, id_inst, id_valid
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline boundary register with reset, flush and freeze
module if_id_reg
    import arm_pkg::*;
#(
    parameter logic [31:0] NOP_INST = arm_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic [WORD_W-1:0] pc_plus4,
    input  logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_inst,
    output logic              id_valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!freeze) begin
            id_pc    <= pc_plus4;
            id_inst  <= inst;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_rom.sv
// rtl/instruction_rom.sv - combinational word-indexed instruction ROM
module instruction_rom
    import arm_pkg::*;
#(
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] NOP_INST  = arm_pkg::NOP_INST
) (
    input  logic [29:0]       word_idx,
    output logic [WORD_W-1:0] inst
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [WORD_W-1:0] rom [MEM_DEPTH];

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_rom
        assign rom[g] = rom_word(g);
    end

    assign inst = ({2'b00, word_idx} < 32'(MEM_DEPTH)) ? rom[word_idx[AW-1:0]] : NOP_INST;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, ROM read, IF/ID register
module if_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] NOP_INST  = arm_pkg::NOP_INST
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.slave  bus
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] inst;

    assign pc_plus4 = pc + 32'd4;
    assign bus.if_pc = pc;

    // Branch wins over freeze so the redirect is never lost behind a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.branch_taken) begin
            pc <= bus.branch_addr & 32'hFFFF_FFFC;
        end else if (!bus.freeze) begin
            pc <= pc_plus4;
        end
    end

    instruction_rom #(
        .MEM_DEPTH (MEM_DEPTH),
        .NOP_INST  (NOP_INST)
    ) u_rom (
        .word_idx (pc[31:2]),
        .inst     (inst)
    );

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.branch_taken),
        .freeze   (bus.freeze),
        .pc_plus4 (pc_plus4),
        .inst     (inst),
        .id_pc    (bus.id_pc),
        .id_inst  (bus.id_inst),
        .id_valid (bus.id_valid)
    );

endmodule
